// File: rtl/gnrc_onehot2therm_stream.sv
// Streaming onehot -> thermometer converter with valid/ready handshakes on
// both sides and a two-entry skid buffer (output register + skid register).
// Illegal (zero-hot or multi-hot) inputs are flagged per beat and counted.
module gnrc_onehot2therm_stream #(
    parameter int N     = 3,
    parameter int CNT_W = 8,
    localparam int M    = N + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [M-1:0]     onehot_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [N-1:0]     therm_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    // Buffer occupancy: EMPTY (nothing held), ONE (output reg), FULL (output + skid)
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t         state_q;
    state_t         state_d;
    logic           out_v;
    logic           skd_v;
    logic           acc;
    logic           drain;
    logic           load_out;
    logic           load_skd;
    logic           out_from_skd;
    logic [N-1:0]   conv_therm;
    logic           conv_err;
    logic [N-1:0]   skd_therm;
    logic           skd_err;

    assign out_v   = (state_q != EMPTY);
    assign skd_v   = (state_q == FULL);
    assign valid_o = out_v;
    assign ready_o = ~skd_v & ~rst_i;
    assign acc     = valid_i & ready_o;
    assign drain   = out_v & ready_i;

    // Convert the incoming code: bit k is set when any onehot bit above k is set
    always_comb begin
        conv_therm = '0;
        for (int k = 0; k < N; k++) begin
            conv_therm[k] = |(onehot_i >> (k + 1));
        end
        conv_err = (onehot_i == '0) || ((onehot_i & (onehot_i - M'(1))) != '0);
    end

    // Next occupancy and which register captures or shifts this cycle
    always_comb begin
        state_d      = state_q;
        load_out     = 1'b0;
        load_skd     = 1'b0;
        out_from_skd = 1'b0;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    load_out = 1'b1;
                    state_d  = ONE;
                end
            end
            ONE: begin
                if (acc && drain) begin
                    load_out = 1'b1;
                end else if (acc) begin
                    load_skd = 1'b1;
                    state_d  = FULL;
                end else if (drain) begin
                    state_d  = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    out_from_skd = 1'b1;
                    state_d      = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Occupancy register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output and skid data registers; skid refills the output when it drains
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            therm_o   <= '0;
            err_o     <= 1'b0;
            skd_therm <= '0;
            skd_err   <= 1'b0;
        end else begin
            if (load_out) begin
                therm_o <= conv_therm;
                err_o   <= conv_err;
            end else if (out_from_skd) begin
                therm_o <= skd_therm;
                err_o   <= skd_err;
            end
            if (load_skd) begin
                skd_therm <= conv_therm;
                skd_err   <= conv_err;
            end
        end
    end

    // Saturating count of illegal beats at input accept; clear wins over old value
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_o <= '0;
        end else if (clr_i) begin
            err_cnt_o <= (acc && conv_err) ? CNT_W'(1) : '0;
        end else if (acc && conv_err && (err_cnt_o != CNT_MAX)) begin
            err_cnt_o <= err_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_gnrc_onehot2therm_stream.sv
// Bench for gnrc_onehot2therm_stream: queue-based reference model checked
// every cycle, plus directed scenarios with literal expected values.
module tb_gnrc_onehot2therm_stream;

    logic       clk_i;
    logic       rst_i;
    logic       clr_i;
    logic       valid_i;
    logic       ready_o;
    logic [3:0] onehot_i;
    logic       valid_o;
    logic       ready_i;
    logic [2:0] therm_o;
    logic       err_o;
    logic [1:0] err_cnt_o;

    int nCompared;
    int nMismatched;
    int cyc;
    int mCnt;
    int mAcc;
    logic [3:0] modelQ[$];
    logic [2:0] logTherm[$];
    logic       logErr[$];
    int         logCyc[$];

    bit         mAccept;
    bit         mDrain;
    int         mHigh;
    int         mOnes;
    logic [3:0] mBeat;

    gnrc_onehot2therm_stream #(.N(3), .CNT_W(2)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (clr_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .onehot_i  (onehot_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .therm_o   (therm_o),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] oh, input logic r, input logic c);
        valid_i  = v;
        onehot_i = oh;
        ready_i  = r;
        clr_i    = c;
        @(posedge clk_i);
        #1;
    endtask

    task automatic clearLog();
        logTherm.delete();
        logErr.delete();
        logCyc.delete();
    endtask

    // Reference model: a FIFO of at most two beats, converted from the highest set bit
    always @(posedge clk_i) begin
        cyc++;
        if (rst_i) begin
            modelQ.delete();
            mCnt = 0;
        end else begin
            mAccept = valid_i && (modelQ.size() < 2);
            mDrain  = (modelQ.size() > 0) && ready_i;
            mHigh = -1;
            mOnes = 0;
            for (int b = 0; b < 4; b++) begin
                if (onehot_i[b]) begin
                    mHigh = b;
                    mOnes++;
                end
            end
            mBeat[2:0] = (mHigh > 0) ? 3'((1 << mHigh) - 1) : 3'd0;
            mBeat[3]   = (mOnes != 1);
            if (mDrain) void'(modelQ.pop_front());
            if (mAccept) begin
                modelQ.push_back(mBeat);
                mAcc++;
            end
            if (clr_i) begin
                mCnt = (mAccept && mBeat[3]) ? 1 : 0;
            end else if (mAccept && mBeat[3] && mCnt < 3) begin
                mCnt++;
            end
        end
    end

    // Compare the DUT against the model away from the active edge
    always @(negedge clk_i) begin
        checkOutput("ready_o", ready_o, (modelQ.size() < 2) && !rst_i);
        checkOutput("valid_o", valid_o, modelQ.size() > 0);
        if (modelQ.size() > 0) begin
            checkOutput("therm_o", therm_o, modelQ[0][2:0]);
            checkOutput("err_o", err_o, modelQ[0][3]);
            if (ready_i && !rst_i) begin
                logTherm.push_back(therm_o);
                logErr.push_back(err_o);
                logCyc.push_back(cyc);
            end
        end
        checkOutput("err_cnt_o", err_cnt_o, mCnt);
    end

    initial begin
        logic [2:0] expTherm[4];
        nCompared   = 0;
        nMismatched = 0;
        cyc  = 0;
        mCnt = 0;
        mAcc = 0;
        rst_i    = 1'b1;
        clr_i    = 1'b0;
        valid_i  = 1'b0;
        onehot_i = 4'b0;
        ready_i  = 1'b0;
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        checkOutput("reset_valid_o", valid_o, 1'b0);
        checkOutput("reset_therm_o", therm_o, 3'b000);
        checkOutput("reset_ready_o", ready_o, 1'b0);
        rst_i = 1'b0;
        #1;
        checkOutput("post_reset_ready_o", ready_o, 1'b1);

        $display("[TB] legal sweep");
        clearLog();
        applyStimulus(1'b1, 4'b0001, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'b0010, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'b0100, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'b1000, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        expTherm = '{3'b000, 3'b001, 3'b011, 3'b111};
        checkOutput("sweep_count", logTherm.size(), 4);
        if (logTherm.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput("sweep_therm", logTherm[i], expTherm[i]);
                checkOutput("sweep_err", logErr[i], 1'b0);
                checkOutput("sweep_consecutive", logCyc[i], logCyc[0] + i);
            end
        end

        $display("[TB] illegal inputs");
        clearLog();
        applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
        checkOutput("illegal_cnt1", err_cnt_o, 2'd1);
        applyStimulus(1'b1, 4'b1010, 1'b1, 1'b0);
        checkOutput("illegal_cnt2", err_cnt_o, 2'd2);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("illegal_count", logTherm.size(), 2);
        if (logTherm.size() == 2) begin
            checkOutput("illegal_therm0", logTherm[0], 3'b000);
            checkOutput("illegal_err0", logErr[0], 1'b1);
            checkOutput("illegal_therm1", logTherm[1], 3'b111);
            checkOutput("illegal_err1", logErr[1], 1'b1);
        end

        $display("[TB] backpressure");
        clearLog();
        applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0);
        checkOutput("bp_ready_after_1", ready_o, 1'b1);
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0);
        checkOutput("bp_ready_after_2", ready_o, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("bp_hold_therm", therm_o, 3'b001);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("bp_ready_back", ready_o, 1'b1);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("bp_count", logTherm.size(), 2);
        if (logTherm.size() == 2) begin
            checkOutput("bp_first", logTherm[0], 3'b001);
            checkOutput("bp_second", logTherm[1], 3'b011);
        end

        $display("[TB] counter saturation");
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
        checkOutput("sat_cleared", err_cnt_o, 2'd0);
        applyStimulus(1'b1, 4'b0011, 1'b1, 1'b0);
        checkOutput("sat_cnt1", err_cnt_o, 2'd1);
        applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
        checkOutput("sat_cnt2", err_cnt_o, 2'd2);
        applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
        checkOutput("sat_cnt3", err_cnt_o, 2'd3);
        applyStimulus(1'b1, 4'b0110, 1'b1, 1'b0);
        checkOutput("sat_cnt4", err_cnt_o, 2'd3);
        applyStimulus(1'b1, 4'b1001, 1'b1, 1'b0);
        checkOutput("sat_cnt5", err_cnt_o, 2'd3);
        applyStimulus(1'b1, 4'b1100, 1'b1, 1'b1);
        checkOutput("sat_clr_with_illegal", err_cnt_o, 2'd1);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);

        $display("[TB] reset while full");
        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0);
        checkOutput("full_ready_o", ready_o, 1'b0);
        clearLog();
        valid_i  = 1'b1;
        onehot_i = 4'b0000;
        rst_i    = 1'b1;
        #1;
        checkOutput("rst_ready_low", ready_o, 1'b0);
        @(posedge clk_i);
        #1;
        checkOutput("rst_valid_o", valid_o, 1'b0);
        checkOutput("rst_therm_o", therm_o, 3'b000);
        checkOutput("rst_err_o", err_o, 1'b0);
        checkOutput("rst_err_cnt_o", err_cnt_o, 2'd0);
        checkOutput("rst_ready_during", ready_o, 1'b0);
        rst_i   = 1'b0;
        valid_i = 1'b0;
        #1;
        checkOutput("rst_ready_after", ready_o, 1'b1);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("rst_no_stale_beat", logTherm.size(), 0);

        $display("[TB] random traffic");
        clearLog();
        mAcc = 0;
        for (int i = 0; i < 60000 && mAcc < 10000; i++) begin
            logic [3:0] oh;
            if ($urandom_range(0, 9) < 8) oh = 4'b0001 << $urandom_range(0, 3);
            else oh = 4'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 9) < 7, oh, $urandom_range(0, 9) < 7,
                          $urandom_range(0, 99) == 0);
        end
        checkOutput("random_beats_reached", mAcc >= 10000, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("random_drained", valid_o, 1'b0);
        checkOutput("random_no_loss", logTherm.size(), mAcc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
